sim_memory_model_responder: RTL
===============================

Name: sim_memory_model_responder

Overview:
- Simulation-side memory target that answers requests from a design-under-test initiator.
- Requests enter a request queue. A control FSM drains the queue in order, applies a programmable access latency, updates or reads a word-addressed array, and returns read data on a valid/busy response channel.
- It is the responder end of the model's request/response interface, used only in the sim environment.

Parameters:
- DATA_N, 32, data width; must be 32 (4 byte lanes).
- MEM_AW, 10, word-address width; array holds 2**MEM_AW words.
- LATENCY, 4, fixed wait cycles per request; legal range 1..255.
- QDEPTH, 8, request queue entries.
- QDEPTH_N, 3, log2(QDEPTH).

Ports:
- iCLOCK  in  1  clock; all logic on rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iREMOVE  in  1  synchronous flush.
- iREQ_VALID  in  1  request present.
- oREQ_BUSY  out  1  queue cannot accept a request.
- iREQ_RW  in  1  1 = write, 0 = read.
- iREQ_ADDR  in  32  byte address.
- iREQ_DATA  in  32  write data.
- iREQ_MASK  in  4  byte enables; bit i controls byte i.
- oRD_VALID  out  1  read response valid.
- iRD_BUSY  in  1  initiator stalls the response.
- oRD_DATA  out  32  read data.

Behaviour:
- Reset/values: inRESET low → queue empty, FSM IDLE, oREQ_BUSY=0, oRD_VALID=0, oRD_DATA=0, counter=0. The memory array is not reset.
- Accept rule: a request is accepted at a rising edge where iREQ_VALID=1 and oREQ_BUSY=0. oREQ_BUSY equals queue-full, with no look-ahead: a push is refused when full even if a pop occurs in the same cycle.
- Addressing: word index = iREQ_ADDR[MEM_AW+1:2]. Upper address bits and bits [1:0] are ignored, so addresses wrap modulo 2**MEM_AW words.
- FSM states: IDLE, WAIT, EXEC, RESP.
  - IDLE: if queue not empty, pop the entry into a holding register, load counter = LATENCY-1, go to WAIT.
  - WAIT: if counter==0 go to EXEC, else decrement the counter.
  - EXEC, write: for each i, write byte i of the array where mask[i]=1; go to IDLE; no response is generated.
  - EXEC, read: oRD_DATA <= mem[index], oRD_VALID <= 1, go to RESP.
  - RESP: at an edge with iRD_BUSY=0, clear oRD_VALID and go to IDLE. While iRD_BUSY=1, oRD_VALID and oRD_DATA are held stable.
- Latency:
  - Isolated read (queue empty, FSM IDLE): oRD_VALID is first high after edge accept+LATENCY+2.
  - Minimum per-request occupancy: read LATENCY+3 cycles, write LATENCY+2 cycles.
- Ordering: strictly in order. A read executed after a write to the same word returns the merged data.
- Capacity: one request in the FSM plus QDEPTH queued.
- iREMOVE (sync, priority over all else):
  - Queue pointers cleared, FSM to IDLE, oRD_VALID=0, pending request discarded.
  - Array contents retained; oRD_DATA keeps its last value.
  - A request presented in the same cycle is dropped.
- Reset mid-operation: identical to reset values; the in-flight request is lost.

Optional Feature:
- Macro: SIM_MEMORY_MODEL_RESPONDER_RANDOM_LATENCY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advances on each pop.
  - At pop, counter = LATENCY-1 + lfsr[1:0], giving 0..3 extra wait cycles.
- Undefined: no LFSR; latency fixed as above.

Decomposition:
- Package sim_memory_model_pkg:
  - FSM state enum.
  - Request entry struct {rw, addr[31:0], data[31:0], mask[3:0]} and its packed width constant REQ_N.
  - LFSR seed and tap constants.
- Sub-module: request queue as an instance of sim_memory_model_sync_fifo (N=REQ_N, DEPTH=QDEPTH, D_N=QDEPTH_N), with iREMOVE wired through.
- FSM, counter, array and LFSR stay in the top module.

Test Plan (LATENCY=4, QDEPTH=8, MEM_AW=10, macro undefined):
- Write 0x10 / 0xDEADBEEF / mask 4'hF, then read 0x10 → oRD_DATA=0xDEADBEEF; for the read alone, oRD_VALID rises after edge accept+6.
- Write 0x20 / 0x11223344 / mask F, then write 0x20 / 0xAABBCCDD / mask 4'b0101, then read 0x20 → 0x11BB33DD.
- iRD_BUSY held at 1, 12 back-to-back reads → exactly 9 accepted. oREQ_BUSY goes high after the 9th accept and stays high until the first response completes.
- Read with iRD_BUSY=1 for 5 cycles after oRD_VALID rises → oRD_VALID and oRD_DATA stable for 5 cycles; exactly one transfer when iRD_BUSY=0.
- Write 0x40 / 0x55AA55AA; queue 3 reads, then pulse iREMOVE during WAIT → no oRD_VALID for those reads, oREQ_BUSY=0. A later read of 0x40 returns 0x55AA55AA.
- Write 0x1000 / 0x0BADF00D, then read 0x0 → 0x0BADF00D (address wrap).

Source files
------------

// File: rtl/sim_memory_model_pkg.sv
// Shared types and constants for the simulation memory responder.
// Used by the request queue and the top-level responder.
package sim_memory_model_pkg;

  // Control FSM states; exported on the debug port of the top module.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // One queued request, captured when it is accepted.
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  localparam int REQ_N = $bits(req_t);

  // 8-bit Fibonacci LFSR: taps 8,6,5,4 map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/sim_memory_model_responder_if.sv
// Request/response bus between an initiator and the memory responder.
// Handshake: a request transfers on a rising edge where iREQ_VALID=1 and
// oREQ_BUSY=0; a response transfers on a rising edge where oRD_VALID=1 and
// iRD_BUSY=0. While a response is stalled, oRD_VALID and oRD_DATA hold.
interface sim_memory_model_responder_if #(
  parameter int DATA_N = 32
);
  logic                  iREQ_VALID;
  logic                  oREQ_BUSY;
  logic                  iREQ_RW;
  logic [31:0]           iREQ_ADDR;
  logic [DATA_N-1:0]     iREQ_DATA;
  logic [DATA_N/8-1:0]   iREQ_MASK;
  logic                  oRD_VALID;
  logic                  iRD_BUSY;
  logic [DATA_N-1:0]     oRD_DATA;

  modport master (
    output iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA, iREQ_MASK, iRD_BUSY,
    input  oREQ_BUSY, oRD_VALID, oRD_DATA
  );

  modport slave (
    input  iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA, iREQ_MASK, iRD_BUSY,
    output oREQ_BUSY, oRD_VALID, oRD_DATA
  );
endinterface

// File: rtl/sim_memory_model_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// Pushes are refused when full even if a pop happens in the same cycle.
module sim_memory_model_sync_fifo #(
  parameter int N     = 69,
  parameter int DEPTH = 8,
  parameter int D_N   = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [N-1:0] i_data,
  input  logic         i_pop,
  output logic [N-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [N-1:0] r_mem [DEPTH];
  logic [D_N-1:0] r_wr_ptr;
  logic [D_N-1:0] r_rd_ptr;
  logic [D_N:0]   r_count;
  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (D_N+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/sim_memory_model_responder.sv
// Simulation memory target: queues requests, waits a programmable latency,
// then writes (byte-masked) or reads a word array and returns read data.
// Optional macro SIM_MEMORY_MODEL_RESPONDER_RANDOM_LATENCY_EN adds 0..3
// LFSR-driven extra wait cycles per request.
module sim_memory_model_responder
  import sim_memory_model_pkg::*;
#(
  parameter int DATA_N   = 32,
  parameter int MEM_AW   = 10,
  parameter int LATENCY  = 4,
  parameter int QDEPTH   = 8,
  parameter int QDEPTH_N = 3
) (
  input  logic   iCLOCK,
  input  logic   inRESET,
  input  logic   iREMOVE,
  sim_memory_model_responder_if.slave bus,
  output state_t oDBG_STATE
);
  // Wide enough for LATENCY-1 plus the optional 0..3 extra cycles.
  localparam int CNT_N = 9;

  state_t            r_state;
  state_t            w_state_nxt;
  req_t              r_hold;
  logic [CNT_N-1:0]  r_cnt;
  logic [CNT_N-1:0]  w_cnt_load;
  logic              r_rd_valid;
  logic [DATA_N-1:0] r_rd_data;
  logic [DATA_N-1:0] r_mem [2**MEM_AW];
  logic [MEM_AW-1:0] w_idx;
  logic [REQ_N-1:0]  w_q;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_unused;

  sim_memory_model_sync_fifo #(
    .N     (REQ_N),
    .DEPTH (QDEPTH),
    .D_N   (QDEPTH_N)
  ) u_req_q (
    .i_clk   (iCLOCK),
    .i_rst_n (inRESET),
    .i_flush (iREMOVE),
    .i_push  (bus.iREQ_VALID),
    .i_data  ({bus.iREQ_RW, bus.iREQ_ADDR, bus.iREQ_DATA, bus.iREQ_MASK}),
    .i_pop   (w_pop),
    .o_data  (w_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.oREQ_BUSY = w_full;
  assign bus.oRD_VALID = r_rd_valid;
  assign bus.oRD_DATA  = r_rd_data;
  assign oDBG_STATE    = r_state;
  assign w_pop         = (r_state == ST_IDLE) && !w_empty && !iREMOVE;
  assign w_idx         = r_hold.addr[MEM_AW+1:2];
  assign w_unused      = ^{r_hold.addr[31:MEM_AW+2], r_hold.addr[1:0]};

`ifdef SIM_MEMORY_MODEL_RESPONDER_RANDOM_LATENCY_EN
  logic [7:0] r_lfsr;

  // LFSR steps once per popped request to randomise its latency.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)   r_lfsr <= LFSR_SEED;
    else if (w_pop) r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_cnt_load = CNT_N'(LATENCY - 1) + CNT_N'(r_lfsr[1:0]);
`else
  assign w_cnt_load = CNT_N'(LATENCY - 1);
`endif

  // FSM state register; flush returns to IDLE.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)     r_state <= ST_IDLE;
    else if (iREMOVE) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state logic: pop, count down, execute, then hand off response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty)     w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_cnt == '0)  w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = r_hold.rw ? ST_IDLE : ST_RESP;
      ST_RESP: if (!bus.iRD_BUSY) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Holding register, latency counter and response registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_hold     <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (iREMOVE) begin
      r_rd_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_hold <= req_t'(w_q);
        r_cnt  <= w_cnt_load;
      end
      if (r_state == ST_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == ST_EXEC && !r_hold.rw) begin
        r_rd_data  <= r_mem[w_idx];
        r_rd_valid <= 1'b1;
      end
      if (r_state == ST_RESP && !bus.iRD_BUSY) r_rd_valid <= 1'b0;
    end
  end

  // Byte-masked array write; contents survive reset and flush.
  always_ff @(posedge iCLOCK) begin
    if (!iREMOVE && r_state == ST_EXEC && r_hold.rw) begin
      for (int i = 0; i < DATA_N/8; i++) begin
        if (r_hold.mask[i]) r_mem[w_idx][8*i +: 8] <= r_hold.data[8*i +: 8];
      end
    end
  end
endmodule
